// File: rtl/par_fifo_mem.sv
// Word storage with a PAR_WRITE-wide write port and a PAR_READ-wide combinational read port.
// Writes take effect at the clock edge, reads have zero latency, and all indices wrap modulo BUFFER_DEPTH.
module par_fifo_mem #(
  parameter int ADDR_WIDTH   = 4,
  parameter int BUFFER_WIDTH = 16,
  parameter int BUFFER_DEPTH = 8,
  parameter int PAR_READ     = 1,
  parameter int PAR_WRITE    = 4
) (
  input  logic                              clk,
  input  logic                              wr_vld,
  input  logic [ADDR_WIDTH-1:0]             wr_base,
  input  logic [PAR_WRITE*BUFFER_WIDTH-1:0] wr_dat,
  input  logic [ADDR_WIDTH-1:0]             rd_base,
  output logic [PAR_READ*BUFFER_WIDTH-1:0]  rd_dat
);
  localparam int IW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

  logic [BUFFER_WIDTH-1:0] mem [BUFFER_DEPTH];

  function automatic logic [IW-1:0] slot(input logic [ADDR_WIDTH-1:0] base, input int off);
    return IW'((int'(base) + off) % BUFFER_DEPTH);
  endfunction

  // Storage carries no reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        mem[slot(wr_base, i)] <= wr_dat[i*BUFFER_WIDTH +: BUFFER_WIDTH];
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int j = 0; j < PAR_READ; j++) begin
      rd_dat[j*BUFFER_WIDTH +: BUFFER_WIDTH] = mem[slot(rd_base, j)];
    end
  end
endmodule

// File: rtl/par_fifo_buf.sv
// Circular FIFO that takes PAR_WRITE words per write and delivers PAR_READ show-ahead words per read. Data is visible on dout the cycle after the write.
// Backpressure: buffer_ready and ready_out gate acceptance. Requests made while the matching flag is low are dropped without any state change.
module par_fifo_buf #(
  parameter int ADDR_WIDTH   = 4,
  parameter int BUFFER_WIDTH = 16,
  parameter int BUFFER_DEPTH = 8,
  parameter int PAR_READ     = 1,
  parameter int PAR_WRITE    = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              ren,
  input  logic                              wen,
  input  logic [PAR_WRITE*BUFFER_WIDTH-1:0] din,
  output logic                              buffer_ready,
  output logic                              ready_out,
  output logic [PAR_READ*BUFFER_WIDTH-1:0]  dout
);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CW-1:0] WR_MAX = CW'(BUFFER_DEPTH - PAR_WRITE);
  localparam logic [CW-1:0] WR_INC = CW'(PAR_WRITE);
  localparam logic [CW-1:0] RD_DEC = CW'(PAR_READ);

  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic [CW-1:0]         cnt;
  logic                  wr_acc;
  logic                  rd_acc;

  function automatic logic [ADDR_WIDTH-1:0] ptr_adv(input logic [ADDR_WIDTH-1:0] p, input int n);
    return ADDR_WIDTH'((int'(p) + n) % BUFFER_DEPTH);
  endfunction

  // Both flags come from the pre-edge count, so a same-cycle read never frees room for a write.
  assign buffer_ready = (cnt <= WR_MAX);
  assign ready_out    = (cnt >= RD_DEC);
  assign wr_acc       = wen && buffer_ready;
  assign rd_acc       = ren && ready_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_acc) wp <= ptr_adv(wp, PAR_WRITE);
      if (rd_acc) rp <= ptr_adv(rp, PAR_READ);
      cnt <= cnt + (wr_acc ? WR_INC : '0) - (rd_acc ? RD_DEC : '0);
    end
  end

  par_fifo_mem #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BUFFER_WIDTH(BUFFER_WIDTH),
    .BUFFER_DEPTH(BUFFER_DEPTH),
    .PAR_READ    (PAR_READ),
    .PAR_WRITE   (PAR_WRITE)
  ) u_mem (
    .clk    (clk),
    .wr_vld (wr_acc),
    .wr_base(wp),
    .wr_dat (din),
    .rd_base(rp),
    .rd_dat (dout)
  );
endmodule

// File: tb/tb_par_fifo_buf.sv
// Scoreboard bench for par_fifo_buf: the driver queues expected words on accepted writes.
// The monitor checks the flags, the show-ahead head and each popped word.
module tb_par_fifo_buf;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int PW = 4;
  localparam int PR = 1;
  localparam int DW = PW * W;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ren;
  logic          wen;
  logic [DW-1:0] din;
  logic          buffer_ready;
  logic          ready_out;
  logic [W-1:0]  dout;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] pop_log[$];
  int   mcnt      = 0;
  logic exp_b     = 1'b1;
  logic exp_r     = 1'b0;
  logic last_wacc = 1'b0;

  par_fifo_buf #(
    .ADDR_WIDTH(4), .BUFFER_WIDTH(W), .BUFFER_DEPTH(D), .PAR_READ(PR), .PAR_WRITE(PW)
  ) dut (
    .clk(clk), .rstn(rstn), .ren(ren), .wen(wen), .din(din),
    .buffer_ready(buffer_ready), .ready_out(ready_out), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle. Acceptance comes from the bench's own occupancy model.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    logic racc;
    wen = w; ren = r; din = d;
    exp_b = ((D - mcnt) >= PW);
    exp_r = (mcnt >= PR);
    last_wacc = w && exp_b;
    racc = r && exp_r;
    if (last_wacc) for (int i = 0; i < PW; i++) exp_q.push_back(d[i*W +: W]);
    @(posedge clk); #1;
    mcnt = mcnt + (last_wacc ? PW : 0) - (racc ? PR : 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && mcnt > 0; k++) step(1'b0, 1'b1, '0);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      chk("buffer_ready", {63'd0, buffer_ready}, {63'd0, exp_b});
      chk("ready_out", {63'd0, ready_out}, {63'd0, exp_r});
      if (ready_out) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL dout_underflow: ready_out=1 but no word expected (t=%0t)", $time);
        end else begin
          chk("dout_head", {48'd0, dout}, {48'd0, exp_q[0]});
          if (ren) begin
            pop_log.push_back(dout);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hand [12];
    hand = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd8, 16'd7, 16'd6, 16'd5,
             16'd10, 16'd14, 16'd16, 16'd19};
    rstn = 1'b0; wen = 1'b0; ren = 1'b0; din = '0;
    #2;
    chk("reset_buffer_ready", {63'd0, buffer_ready}, 64'd1);
    chk("reset_ready_out", {63'd0, ready_out}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Single write; the following idle cycle shows word 1 at the head
    step(1'b1, 1'b0, {16'd4, 16'd3, 16'd2, 16'd1});
    chk("single_write_dout", {48'd0, dout}, 64'd1);
    step(1'b0, 1'b0, '0);

    // Concurrent write and read, then a blocked write retried until there is room
    pop_log.delete();
    step(1'b1, 1'b1, {16'd5, 16'd6, 16'd7, 16'd8});
    chk("concurrent_dout", {48'd0, dout}, 64'd2);
    chk("concurrent_full", {63'd0, buffer_ready}, 64'd0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, {16'd19, 16'd16, 16'd14, 16'd10});
      if (last_wacc) break;
    end
    drain();
    chk("seq_len", 64'(pop_log.size()), 64'd12);
    for (int i = 0; i < 12 && i < pop_log.size(); i++)
      chk("seq_word", {48'd0, pop_log[i]}, {48'd0, hand[i]});

    // Fill to capacity; further writes must be ignored
    step(1'b1, 1'b0, {16'h104, 16'h103, 16'h102, 16'h101});
    step(1'b1, 1'b0, {16'h204, 16'h203, 16'h202, 16'h201});
    step(1'b1, 1'b0, {4{16'hdead}});
    step(1'b1, 1'b0, {4{16'hbeef}});
    chk("full_head", {48'd0, dout}, 64'h101);
    drain();
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    chk("empty_ready_out", {63'd0, ready_out}, 64'd0);
    step(1'b1, 1'b0, {16'h304, 16'h303, 16'h302, 16'h301});
    chk("after_drain_dout", {48'd0, dout}, 64'h301);
    drain();

    // Asynchronous reset mid-cycle with five words stored
    step(1'b1, 1'b0, {16'h404, 16'h403, 16'h402, 16'h401});
    step(1'b1, 1'b0, {16'h504, 16'h503, 16'h502, 16'h501});
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_buffer_ready", {63'd0, buffer_ready}, 64'd1);
    chk("midrst_ready_out", {63'd0, ready_out}, 64'd0);
    exp_q.delete();
    mcnt = 0; exp_b = 1'b1; exp_r = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    step(1'b1, 1'b0, {16'h000d, 16'h000c, 16'h000b, 16'h000a});
    chk("post_reset_dout", {48'd0, dout}, 64'h000a);
    drain();
    step(1'b0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
